// File: rtl/bram_port_req_ctrl_pkg.sv
// Constants shared between the BRAM wrapper and its port request controllers.
package bram_port_req_ctrl_pkg;

  typedef enum logic {
    LOW_LATENCY      = 1'b0,
    HIGH_PERFORMANCE = 1'b1
  } perf_mode_e;

  localparam int RD_LAT_LOW_LATENCY      = 1;
  localparam int RD_LAT_HIGH_PERFORMANCE = 2;

  // BRAM read latency implied by the wrapper's performance mode.
  function automatic int rd_lat_of(perf_mode_e mode);
    return (mode == LOW_LATENCY) ? RD_LAT_LOW_LATENCY : RD_LAT_HIGH_PERFORMANCE;
  endfunction

endpackage

// File: rtl/bram_resp_fifo.sv
// Synchronous FIFO with wrapping MSB-extended pointers; reusable outside the BRAM front-end.
module bram_resp_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // NOTE: non-blocking (<=) for every flop so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bram_port_req_ctrl.sv
// Request front-end for one BRAM port: zero-latency issue, read tracking and a credited response FIFO.
module bram_port_req_ctrl
  import bram_port_req_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 18,
  parameter int TAG_W     = 4,
  parameter int RD_LAT    = rd_lat_of(HIGH_PERFORMANCE),
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_rst,
  output logic              bram_regce,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              busy
);

  localparam int CRD_W = $clog2(BUF_DEPTH + 1);

  logic [CRD_W-1:0]        crd;
  logic [CRD_W-1:0]        crd_nxt;
  logic                    accept;
  logic                    rd_accept;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [DATA_W+TAG_W-1:0] fifo_rdata;
  logic [RD_LAT-1:0]       pipe_vld;
  logic [TAG_W-1:0]        pipe_tag [RD_LAT];

  // A credit reserves a FIFO slot for each read from issue until its response pops.
  assign req_rdy   = !rst && (crd < CRD_W'(BUF_DEPTH));
  assign accept    = req_val && req_rdy;
  assign rd_accept = accept && !req_we;

  assign bram_en    = accept;
  assign bram_we    = accept && req_we;
  assign bram_addr  = req_addr;
  assign bram_din   = req_wdata;
  assign bram_rst   = rst;
  assign bram_regce = !rst;

  assign push     = pipe_vld[RD_LAT-1];
  assign resp_val = !rst && !fifo_empty;
  assign pop      = resp_val && resp_rdy;
  assign {resp_data, resp_tag} = fifo_rdata;
  assign busy     = !rst && (crd != '0);

  // NOTE: default first so every path assigns crd_nxt and no latch is inferred.
  always_comb begin
    crd_nxt = crd;
    if (rd_accept && !pop)      crd_nxt = crd + 1'b1;
    else if (!rd_accept && pop) crd_nxt = crd - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crd      <= '0;
      pipe_vld <= '0;
    end else begin
      crd         <= crd_nxt;
      pipe_vld[0] <= rd_accept;
      for (int i = 1; i < RD_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_tag[0] <= req_tag;
    for (int i = 1; i < RD_LAT; i++) pipe_tag[i] <= pipe_tag[i-1];
  end

  bram_resp_fifo #(
    .WIDTH (DATA_W + TAG_W),
    .DEPTH (BUF_DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({bram_dout, pipe_tag[RD_LAT-1]}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The credit scheme guarantees a reserved slot for every returning read.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_bram_port_req_ctrl.sv
// Bench for bram_port_req_ctrl: one RD_LAT=2 and one RD_LAT=1 instance, each behind a behavioural BRAM.
module tb_bram_port_req_ctrl;
  import bram_port_req_ctrl_pkg::*;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 18;
  localparam int TAG_W     = 4;
  localparam int BUF_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus, steered to one instance by sel (0 = high-performance, 1 = low-latency).
  logic              sel       = 1'b0;
  logic              req_val   = 1'b0;
  logic              req_we    = 1'b0;
  logic [ADDR_W-1:0] req_addr  = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [TAG_W-1:0]  req_tag   = '0;
  logic              resp_rdy  = 1'b0;

  logic h_req_rdy, h_resp_val, h_bram_en, h_bram_we, h_bram_rst, h_bram_regce, h_busy;
  logic l_req_rdy, l_resp_val, l_bram_en, l_bram_we, l_bram_rst, l_bram_regce, l_busy;
  logic [DATA_W-1:0] h_resp_data, h_bram_din, h_dout, h_d1;
  logic [DATA_W-1:0] l_resp_data, l_bram_din, l_d1;
  logic [TAG_W-1:0]  h_resp_tag, l_resp_tag;
  logic [ADDR_W-1:0] h_bram_addr, l_bram_addr;

  bram_port_req_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
    .RD_LAT(rd_lat_of(HIGH_PERFORMANCE)), .BUF_DEPTH(BUF_DEPTH)
  ) u_hi (
    .clk(clk), .rst(rst),
    .req_val(req_val && !sel), .req_rdy(h_req_rdy), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_val(h_resp_val), .resp_rdy(resp_rdy && !sel),
    .resp_data(h_resp_data), .resp_tag(h_resp_tag),
    .bram_en(h_bram_en), .bram_we(h_bram_we), .bram_addr(h_bram_addr),
    .bram_din(h_bram_din), .bram_rst(h_bram_rst), .bram_regce(h_bram_regce),
    .bram_dout(h_dout), .busy(h_busy)
  );

  bram_port_req_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
    .RD_LAT(rd_lat_of(LOW_LATENCY)), .BUF_DEPTH(BUF_DEPTH)
  ) u_lo (
    .clk(clk), .rst(rst),
    .req_val(req_val && sel), .req_rdy(l_req_rdy), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_val(l_resp_val), .resp_rdy(resp_rdy && sel),
    .resp_data(l_resp_data), .resp_tag(l_resp_tag),
    .bram_en(l_bram_en), .bram_we(l_bram_we), .bram_addr(l_bram_addr),
    .bram_din(l_bram_din), .bram_rst(l_bram_rst), .bram_regce(l_bram_regce),
    .bram_dout(l_d1), .busy(l_busy)
  );

  // Write-first BRAM models: two-stage output for RD_LAT=2, single stage for RD_LAT=1.
  logic [DATA_W-1:0] mem_h [1024];
  logic [DATA_W-1:0] mem_l [1024];

  always @(posedge clk) begin
    if (h_bram_en) begin
      if (h_bram_we) begin
        mem_h[h_bram_addr] <= h_bram_din;
        h_d1 <= h_bram_din;
      end else begin
        h_d1 <= mem_h[h_bram_addr];
      end
    end
    if (h_bram_rst)        h_dout <= '0;
    else if (h_bram_regce) h_dout <= h_d1;
  end

  always @(posedge clk) begin
    if (l_bram_en && l_bram_we) mem_l[l_bram_addr] <= l_bram_din;
    if (l_bram_rst)                     l_d1 <= '0;
    else if (l_bram_en && l_bram_regce) l_d1 <= l_bram_we ? l_bram_din : mem_l[l_bram_addr];
  end

  // Views of the selected instance.
  logic              c_req_rdy, c_resp_val, c_bram_en, c_bram_we, c_busy;
  logic [DATA_W-1:0] c_resp_data, c_bram_din;
  logic [TAG_W-1:0]  c_resp_tag;
  logic [ADDR_W-1:0] c_bram_addr;
  int                lat;

  always_comb begin
    c_req_rdy   = sel ? l_req_rdy   : h_req_rdy;
    c_resp_val  = sel ? l_resp_val  : h_resp_val;
    c_resp_data = sel ? l_resp_data : h_resp_data;
    c_resp_tag  = sel ? l_resp_tag  : h_resp_tag;
    c_bram_en   = sel ? l_bram_en   : h_bram_en;
    c_bram_we   = sel ? l_bram_we   : h_bram_we;
    c_bram_addr = sel ? l_bram_addr : h_bram_addr;
    c_bram_din  = sel ? l_bram_din  : h_bram_din;
    c_busy      = sel ? l_busy      : h_busy;
    lat         = sel ? 1 : 2;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: memory contents plus the ordered list of reads accepted but not yet popped.
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    int                cyc;
  } exp_t;

  exp_t              exp_q [$];
  logic [DATA_W-1:0] ref_mem [2][1024];
  int                pend;
  logic              acc;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      pend = exp_q.size();
      acc  = req_val && c_req_rdy;
      n_vec++;
      if (c_req_rdy !== (pend < BUF_DEPTH) || c_busy !== (pend != 0)) begin
        n_err++;
        $display("FAIL credit @%0d: req_rdy=%b busy=%b, expected rdy=%b busy=%b (outstanding=%0d)",
                 cyc, c_req_rdy, c_busy, pend < BUF_DEPTH, pend != 0, pend);
      end
      n_vec++;
      if (c_bram_en !== acc || c_bram_we !== (acc && req_we)) begin
        n_err++;
        $display("FAIL issue @%0d: bram_en=%b bram_we=%b, expected %b %b",
                 cyc, c_bram_en, c_bram_we, acc, acc && req_we);
      end
      if (acc) begin
        n_vec++;
        if (c_bram_addr !== req_addr || (req_we && c_bram_din !== req_wdata)) begin
          n_err++;
          $display("FAIL issue_addr @%0d: addr=%h din=%h, expected addr=%h din=%h",
                   cyc, c_bram_addr, c_bram_din, req_addr, req_wdata);
        end
      end
      if (c_resp_val) begin
        n_vec++;
        if (pend == 0) begin
          n_err++;
          $display("FAIL spurious_resp @%0d: resp_val=1, expected 0 (no reads outstanding)", cyc);
        end else if (cyc < exp_q[0].cyc + lat + 1) begin
          n_err++;
          $display("FAIL early_resp @%0d: resp_val=1, read accepted @%0d, expected no earlier than @%0d",
                   cyc, exp_q[0].cyc, exp_q[0].cyc + lat + 1);
        end else if (resp_rdy) begin
          n_vec++;
          if (c_resp_data !== exp_q[0].data || c_resp_tag !== exp_q[0].tag) begin
            n_err++;
            $display("FAIL resp @%0d: data=%h tag=%h, expected data=%h tag=%h",
                     cyc, c_resp_data, c_resp_tag, exp_q[0].data, exp_q[0].tag);
          end
          void'(exp_q.pop_front());
        end
      end
      if (acc) begin
        if (req_we) ref_mem[sel][req_addr] = req_wdata;
        else        exp_q.push_back('{ref_mem[sel][req_addr], req_tag, cyc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted; returns the acceptance cycle.
  task automatic send(input bit we, input int addr, input int data, input int tag, output int acc_cyc);
    req_val   = 1'b1;
    req_we    = we;
    req_addr  = ADDR_W'(addr);
    req_wdata = DATA_W'(data);
    req_tag   = TAG_W'(tag);
    acc_cyc   = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (c_req_rdy) begin
        acc_cyc = cyc;
        break;
      end
    end
    n_vec++;
    if (acc_cyc < 0) begin
      n_err++;
      $display("FAIL send_timeout: req_rdy=%b after 100 cycles, expected 1", c_req_rdy);
    end
    tick();
    req_val = 1'b0;
  endtask

  task automatic wait_idle();
    resp_rdy = 1'b1;
    req_val  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!c_busy) break;
    end
    n_vec++;
    if (c_busy !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: busy=%b outstanding=%0d, expected busy=0 outstanding=0", c_busy, exp_q.size());
    end
    tick();
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    req_val  = 1'b1;
    req_we   = 1'b1;
    resp_rdy = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if ({h_req_rdy, h_resp_val, h_bram_en, h_bram_we, h_bram_rst, h_bram_regce, h_busy} !== 7'b0000100) begin
        n_err++;
        $display("FAIL reset_state: rdy/val/en/we/rst/regce/busy=%b, expected 0000100",
                 {h_req_rdy, h_resp_val, h_bram_en, h_bram_we, h_bram_rst, h_bram_regce, h_busy});
      end
    end
    tick();
    rst     = 1'b0;
    req_val = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({h_req_rdy, h_busy, h_bram_rst, h_bram_regce} !== 4'b1001) begin
      n_err++;
      $display("FAIL reset_release: rdy/busy/bram_rst/regce=%b, expected 1001",
               {h_req_rdy, h_busy, h_bram_rst, h_bram_regce});
    end
    tick();
  endtask

  task automatic test_basic(input int addr, input int data, input int tag);
    int a;
    resp_rdy = 1'b1;
    send(1'b1, addr, data, 0, a);
    send(1'b0, addr, 0, tag, a);
    for (int j = 1; j <= lat + 1; j++) begin
      @(negedge clk);
      n_vec++;
      if (j <= lat) begin
        if (c_resp_val !== 1'b0) begin
          n_err++;
          $display("FAIL basic_latency: resp_val=1 %0d cycles after accept, expected 0", j);
        end
      end else if (c_resp_val !== 1'b1 || c_resp_data !== DATA_W'(data) || c_resp_tag !== TAG_W'(tag)) begin
        n_err++;
        $display("FAIL basic_resp: val=%b data=%h tag=%h, expected val=1 data=%h tag=%h",
                 c_resp_val, c_resp_data, c_resp_tag, DATA_W'(data), TAG_W'(tag));
      end
    end
    tick();
  endtask

  task automatic test_streaming(input int n);
    int a;
    resp_rdy = 1'b1;
    for (int i = 0; i < n; i++) send(1'b1, i, i, 0, a);
    for (int k = 0; k <= n + lat; k++) begin
      req_val  = (k < n);
      req_we   = 1'b0;
      req_addr = ADDR_W'(k);
      req_tag  = TAG_W'(k);
      @(negedge clk);
      if (k < n) begin
        n_vec++;
        if (c_req_rdy !== 1'b1) begin
          n_err++;
          $display("FAIL stream_rdy: req_rdy=%b on read %0d, expected 1", c_req_rdy, k);
        end
      end
      if (k >= lat + 1) begin
        n_vec++;
        if (c_resp_val !== 1'b1 || c_resp_data !== DATA_W'(k - lat - 1)) begin
          n_err++;
          $display("FAIL stream_resp: val=%b data=%h, expected val=1 data=%h",
                   c_resp_val, c_resp_data, DATA_W'(k - lat - 1));
        end
      end
      tick();
    end
    req_val = 1'b0;
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    resp_rdy = 1'b0;
    req_we   = 1'b0;
    for (int k = 0; k < 10; k++) begin
      req_val  = 1'b1;
      req_addr = ADDR_W'(10 + k);
      req_tag  = TAG_W'(k);
      @(negedge clk);
      if (c_req_rdy) n_acc++;
      tick();
    end
    n_vec++;
    if (n_acc != BUF_DEPTH) begin
      n_err++;
      $display("FAIL stall_accepts: %0d reads accepted, expected %0d", n_acc, BUF_DEPTH);
    end
    req_addr = ADDR_W'(20);
    req_tag  = TAG_W'(4);
    resp_rdy = 1'b1;
    @(negedge clk);
    n_vec++;
    if (c_req_rdy !== 1'b0 || c_resp_val !== 1'b1 || c_resp_data !== DATA_W'(10) || c_resp_tag !== TAG_W'(0)) begin
      n_err++;
      $display("FAIL first_pop: rdy=%b val=%b data=%h tag=%h, expected rdy=0 val=1 data=00a tag=0",
               c_req_rdy, c_resp_val, c_resp_data, c_resp_tag);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (c_req_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL credit_return: req_rdy=%b the cycle after the first pop, expected 1", c_req_rdy);
    end
    tick();
    wait_idle();
  endtask

  task automatic test_reset_midstream();
    int a;
    resp_rdy = 1'b0;
    send(1'b0, 0, 0, 1, a);
    send(1'b0, 1, 0, 2, a);
    send(1'b0, 2, 0, 3, a);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({h_bram_rst, h_req_rdy, h_resp_val, h_busy} !== 4'b1000) begin
      n_err++;
      $display("FAIL midreset: bram_rst/rdy/val/busy=%b, expected 1000",
               {h_bram_rst, h_req_rdy, h_resp_val, h_busy});
    end
    tick();
    rst      = 1'b0;
    resp_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if (h_resp_val !== 1'b0 || h_busy !== 1'b0 || h_req_rdy !== 1'b1) begin
        n_err++;
        $display("FAIL post_reset %0d: val=%b busy=%b rdy=%b, expected val=0 busy=0 rdy=1",
                 i, h_resp_val, h_busy, h_req_rdy);
      end
      tick();
    end
  endtask

  task automatic test_mixed(input int n);
    for (int i = 0; i < n; i++) begin
      req_val   = ($urandom_range(0, 3) != 0);
      req_we    = ($urandom_range(0, 2) == 0);
      req_addr  = ADDR_W'($urandom_range(0, 15));
      req_wdata = DATA_W'($urandom);
      req_tag   = TAG_W'($urandom);
      resp_rdy  = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      tick();
    end
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic(5, 'h2A5, 3);
    test_streaming(64);
    test_backpressure();
    test_reset_midstream();
    test_mixed(400);
    sel = 1'b1;
    test_basic(7, 'h155, 9);
    test_streaming(16);
    test_mixed(200);
    sel = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
